// File: rtl/ltssm_pkg.sv
// Shared symbol constants, scheduler state encoding and TS field bundle
// for the transmit ordered-set scheduler.
package ltssm_pkg;

  // Control and data symbol values on the 8b10b encoder input
  localparam logic [7:0] COM      = 8'hBC;
  localparam logic [7:0] PAD      = 8'hF7;
  localparam logic [7:0] SKP      = 8'h1C;
  localparam logic [7:0] TS1_ID   = 8'h4A;
  localparam logic [7:0] TS2_ID   = 8'h45;
  localparam logic [7:0] IDLE_SYM = 8'h00;

  // Ordered-set lengths in symbols
  localparam int TS_LEN  = 16;
  localparam int SKP_LEN = 4;

  // Width of the SKP interval counter
  localparam int SKP_CNT_W = 11;

  typedef enum logic [2:0] {
    ST_QUIET = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SKP   = 3'd2,
    ST_TS    = 3'd3,
    ST_DATA  = 3'd4
  } sched_state_t;

  // Training-set fields, captured once at symbol 0 of each set
  typedef struct packed {
    logic       ts2;
    logic       pad;
    logic [7:0] link;
    logic [7:0] lane;
    logic [7:0] n_fts;
    logic [7:0] rate_id;
    logic [7:0] train_ctl;
  } ts_cfg_t;

  // Returns {k, symbol} for position idx of a training set
  function automatic logic [8:0] ts_symbol(input ts_cfg_t cfg, input logic [3:0] idx);
    logic [8:0] w;
    case (idx)
      4'd0:    w = {1'b1, COM};
      4'd1:    w = cfg.pad ? {1'b1, PAD} : {1'b0, cfg.link};
      4'd2:    w = cfg.pad ? {1'b1, PAD} : {1'b0, cfg.lane};
      4'd3:    w = {1'b0, cfg.n_fts};
      4'd4:    w = {1'b0, cfg.rate_id};
      4'd5:    w = {1'b0, cfg.train_ctl};
      default: w = {1'b0, (cfg.ts2 ? TS2_ID : TS1_ID)};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/skp_timer.sv
// SKP interval timer: counts transmitted symbols and raises a sticky
// pending flag each time the interval elapses. An expiry that arrives
// while a request is already pending is simply absorbed.
module skp_timer
  import ltssm_pkg::*;
#(
  parameter int INTERVAL = 1180
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick,     // a symbol was transmitted this cycle
  input  logic take,     // an SKP set is starting; consume the request
  input  logic clear,    // link quiet: restart the interval from zero
  output logic pending
);

  localparam logic [SKP_CNT_W-1:0] LAST = SKP_CNT_W'(INTERVAL - 1);

  logic [SKP_CNT_W-1:0] count;
  logic                 expire;

  assign expire = tick && (count == LAST);

  // Interval counter, wraps to zero on expiry
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= expire ? '0 : count + 1'b1;
    end
  end

  // Pending flag; a fresh expiry outranks consumption in the same cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending <= 1'b0;
    end else if (clear) begin
      pending <= 1'b0;
    end else if (expire) begin
      pending <= 1'b1;
    end else if (take) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/tx_os_scheduler.sv
// Transmit ordered-set scheduler. Chooses one symbol per clock among SKP
// sets, TS1/TS2 training sets, link-layer data and logical idle, and
// registers it toward the 8b10b encoder.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_QUIET | enable low, nothing transmitted
// ST_IDLE  | set/packet boundary: select next source, else logical idle
// ST_SKP   | emitting SKP symbols 1..3 (COM went out on selection)
// ST_TS    | emitting TS symbols 1..15 from the captured fields
// ST_DATA  | inside a packet, waiting for the symbol marked last
module tx_os_scheduler
  import ltssm_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       ts_req_i,
  input  logic       ts2_sel_i,
  input  logic [7:0] link_num_i,
  input  logic [7:0] lane_num_i,
  input  logic       pad_i,
  input  logic [7:0] n_fts_i,
  input  logic [7:0] rate_id_i,
  input  logic [7:0] train_ctl_i,
  input  logic       data_valid_i,
  input  logic [7:0] data_i,
  input  logic       data_k_i,
  input  logic       data_last_i,
  output logic       data_ready_o,
  output logic [7:0] tx_sym_o,
  output logic       tx_k_o,
  output logic       tx_valid_o,
  output logic       is_ordered_set_o,
  output logic       bypass_scrambler_o,
  output logic       ts_sent_o
);

  sched_state_t state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  ts_cfg_t      cfg_q, cfg_d, cfg_in;

  logic [7:0]   sym_d;
  logic         k_d;
  logic         valid_d;
  logic         os_d;
  logic         sent_d;

  logic         skp_pending;
  logic         skp_take;
  logic         skp_clear;
  logic [8:0]   ts_word;

  localparam logic [3:0] SKP_LAST = 4'(SKP_LEN - 1);
  localparam logic [3:0] TS_LAST  = 4'(TS_LEN - 1);

  skp_timer #(
    .INTERVAL (SKP_INTERVAL)
  ) u_skp (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .tick    (tx_valid_o),
    .take    (skp_take),
    .clear   (skp_clear),
    .pending (skp_pending)
  );

  // Bundle the live TS field inputs so they can be captured at symbol 0
  always_comb begin
    cfg_in           = '0;
    cfg_in.ts2       = ts2_sel_i;
    cfg_in.pad       = pad_i;
    cfg_in.link      = link_num_i;
    cfg_in.lane      = lane_num_i;
    cfg_in.n_fts     = n_fts_i;
    cfg_in.rate_id   = rate_id_i;
    cfg_in.train_ctl = train_ctl_i;
  end

  assign ts_word = ts_symbol(cfg_q, idx_q);

  // Next-state and next-symbol selection
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cfg_d        = cfg_q;
    sym_d        = 8'h00;
    k_d          = 1'b0;
    valid_d      = 1'b0;
    os_d         = 1'b0;
    sent_d       = 1'b0;
    data_ready_o = 1'b0;
    skp_take     = 1'b0;
    skp_clear    = 1'b0;

    case (state_q)
      ST_QUIET: begin
        skp_clear = 1'b1;
        if (en_i) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (!en_i) begin
          // Enable dropping outranks any new selection, including a TS request
          skp_clear = 1'b1;
          state_d   = ST_QUIET;
        end else if (skp_pending) begin
          skp_take = 1'b1;
          sym_d    = COM;
          k_d      = 1'b1;
          valid_d  = 1'b1;
          os_d     = 1'b1;
          idx_d    = 4'd1;
          state_d  = ST_SKP;
        end else if (ts_req_i) begin
          cfg_d   = cfg_in;
          sym_d   = COM;
          k_d     = 1'b1;
          valid_d = 1'b1;
          os_d    = 1'b1;
          idx_d   = 4'd1;
          state_d = ST_TS;
        end else if (data_valid_i) begin
          // First symbol of a packet is accepted right at the boundary
          data_ready_o = 1'b1;
          sym_d        = data_i;
          k_d          = data_k_i;
          valid_d      = 1'b1;
          state_d      = data_last_i ? ST_IDLE : ST_DATA;
        end else begin
          sym_d   = IDLE_SYM;
          valid_d = 1'b1;
        end
      end

      ST_SKP: begin
        // Ordered sets always run to completion regardless of enable
        sym_d   = SKP;
        k_d     = 1'b1;
        valid_d = 1'b1;
        os_d    = 1'b1;
        if (idx_q == SKP_LAST) begin
          idx_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end

      ST_TS: begin
        sym_d   = ts_word[7:0];
        k_d     = ts_word[8];
        valid_d = 1'b1;
        os_d    = 1'b1;
        if (idx_q == TS_LAST) begin
          sent_d  = 1'b1;
          idx_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end

      ST_DATA: begin
        if (!en_i) begin
          // Packets are abandoned at once when the link is disabled
          skp_clear = 1'b1;
          state_d   = ST_QUIET;
        end else if (data_valid_i) begin
          data_ready_o = 1'b1;
          sym_d        = data_i;
          k_d          = data_k_i;
          valid_d      = 1'b1;
          if (data_last_i) begin
            state_d = ST_IDLE;
          end
        end else begin
          // Source stalled mid-packet: fill with logical idle, stay in packet
          sym_d   = IDLE_SYM;
          valid_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_QUIET;
        idx_d   = 4'd0;
      end
    endcase
  end

  // State, set position and captured TS fields
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_QUIET;
      idx_q   <= 4'd0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cfg_q   <= cfg_d;
    end
  end

  // Registered symbol stream and qualifiers toward the encoder
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_sym_o           <= 8'h00;
      tx_k_o             <= 1'b0;
      tx_valid_o         <= 1'b0;
      is_ordered_set_o   <= 1'b0;
      bypass_scrambler_o <= 1'b0;
      ts_sent_o          <= 1'b0;
    end else begin
      tx_sym_o           <= sym_d;
      tx_k_o             <= k_d;
      tx_valid_o         <= valid_d;
      is_ordered_set_o   <= os_d;
      bypass_scrambler_o <= os_d;
      ts_sent_o          <= sent_d;
    end
  end

endmodule
